// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 program loader and the CPU memory it feeds.
package mips32_pkg;

  localparam int MEM_DEPTH      = 1024;
  localparam int HDR_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;

  // Byte positions of the header fields within the frame.
  localparam int POS_CNT_H = 0;
  localparam int POS_CNT_L = 1;
  localparam int POS_ADR_H = 2;
  localparam int POS_ADR_L = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  typedef struct packed {
    logic [15:0] cnt;
    logic [15:0] adr;
  } hdr_t;

  function automatic hdr_t unpack_hdr(input logic [31:0] w);
    return hdr_t'(w);
  endfunction

endpackage

// File: rtl/mips32_prog_loader_if.sv
// Byte stream, memory write port and CPU control signals of the program loader.
interface mips32_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport loader (
    input  start, in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
  );

  modport host (
    output start, in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/mips32_byte_packer.sv
// Packs accepted bytes MSB-first into 32-bit words; flags the 4th byte of each word.
module mips32_byte_packer (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_vld,
  input  logic [7:0]  i_byte,
  output logic        o_word_done,
  output logic [31:0] o_word
);

  logic [1:0]  r_idx;
  logic [23:0] r_sr;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= 2'd0;
      r_sr  <= 24'd0;
    end else if (i_clr) begin
      r_idx <= 2'd0;
      r_sr  <= 24'd0;
    end else if (i_vld) begin
      r_idx <= r_idx + 2'd1;
      r_sr  <= {r_sr[15:0], i_byte};
    end
  end

  // The completing byte is merged combinationally so the word is ready in its accept cycle.
  assign o_word_done = i_vld & (r_idx == 2'd3);
  assign o_word      = {r_sr, i_byte};

endmodule

// File: rtl/mips32_prog_loader.sv
// Framed byte-stream loader: writes an image into CPU memory and releases the CPU
// only after the trailing XOR checksum matches.
//   state | meaning
//   IDLE  | waiting for start, CPU held
//   HDR   | collecting count and start address
//   DATA  | collecting payload words, one memory write per word
//   CSUM  | waiting for the checksum byte
//   DONE  | image committed, CPU released
//   ERR   | bad count or checksum, CPU held until next start
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic                clk1,
  input  logic                rst_n,
  mips32_prog_loader_if.loader bus
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  state_t            r_state;
  logic              r_in_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_err;
  logic [7:0]        r_xor;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [CNT_W-1:0]  r_words_left;

  logic              w_xfer;
  logic              w_start_ok;
  logic              w_pack_vld;
  logic              w_word_done;
  logic [31:0]       w_word;
  hdr_t              w_hdr;

  assign w_xfer     = bus.in_valid & r_in_ready;
  assign w_start_ok = bus.start &
                      ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_pack_vld = w_xfer & ((r_state == ST_HDR) || (r_state == ST_DATA));
  assign w_hdr      = unpack_hdr(w_word);

  mips32_byte_packer u_packer (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .i_clr       (w_start_ok),
    .i_vld       (w_pack_vld),
    .i_byte      (bus.in_data),
    .o_word_done (w_word_done),
    .o_word      (w_word)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_in_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_xor        <= 8'd0;
      r_wr_addr    <= '0;
      r_words_left <= '0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      if (w_xfer) r_xor <= r_xor ^ bus.in_data;

      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.start) begin
            r_state    <= ST_HDR;
            r_in_ready <= 1'b1;
            r_cpu_hold <= 1'b1;
            r_err      <= 1'b0;
            r_xor      <= 8'd0;
          end
        end
        ST_HDR: begin
          if (w_word_done) begin
            // Address bits above ADDR_W are dropped on purpose.
            r_wr_addr    <= ADDR_W'(w_hdr.adr);
            r_words_left <= CNT_W'(w_hdr.cnt);
            if (w_hdr.cnt > 16'(MAX_WORDS)) begin
              r_state    <= ST_ERR;
              r_in_ready <= 1'b0;
              r_err      <= 1'b1;
            end else if (w_hdr.cnt == 16'd0) begin
              r_state <= ST_CSUM;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_word_done) begin
            r_mem_we     <= 1'b1;
            r_mem_addr   <= r_wr_addr;
            r_mem_wdata  <= w_word;
            r_wr_addr    <= r_wr_addr + ADDR_W'(1);
            r_words_left <= r_words_left - CNT_W'(1);
            if (r_words_left == CNT_W'(1)) r_state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (w_xfer) begin
            r_in_ready <= 1'b0;
            if (bus.in_data == r_xor) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.cpu_hold  = r_cpu_hold;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Self-checking bench for mips32_prog_loader: table of frames, random frames, and
// hand-written reset / oversize-count sequences against a frame-level model.
module tb_mips32_prog_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;
  localparam int DEPTH     = 1 << ADDR_W;

  logic clk1  = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  mips32_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  mips32_prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int n;
    int addr;
    bit corrupt;
    bit use_prog;
    int max_gap;
    bit exp_done;
    bit exp_err;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] prog[10];
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [7:0]  frame_q[$];
  logic [31:0] exp_data[$];
  int          exp_addr[$];
  logic [31:0] got_data[$];
  int          got_addr[$];
  int          done_cnt = 0;
  int          hold_in_done = 0;

  // Write/done monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk1) begin
    #1;
    if (bus.mem_we) begin
      got_data.push_back(bus.mem_wdata);
      got_addr.push_back(int'(bus.mem_addr));
    end
    if (bus.done) begin
      done_cnt++;
      if (bus.cpu_hold) hold_in_done++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame model: header, big-endian words, XOR of all preceding bytes.
  task automatic build(input int n, input int addr, input bit corrupt, input bit use_prog);
    logic [7:0]  x;
    logic [31:0] w;
    frame_q.delete();
    exp_data.delete();
    exp_addr.delete();
    frame_q.push_back(8'((n >> 8) & 255));
    frame_q.push_back(8'(n & 255));
    frame_q.push_back(8'((addr >> 8) & 255));
    frame_q.push_back(8'(addr & 255));
    for (int k = 0; k < n; k++) begin
      w = use_prog ? prog[k] : $urandom;
      exp_data.push_back(w);
      exp_addr.push_back((addr + k) % DEPTH);
      frame_q.push_back(w[31:24]);
      frame_q.push_back(w[23:16]);
      frame_q.push_back(w[15:8]);
      frame_q.push_back(w[7:0]);
    end
    x = 8'd0;
    foreach (frame_q[i]) x = x ^ frame_q[i];
    if (corrupt) x = x ^ 8'h01;
    frame_q.push_back(x);
  endtask

  // Pulses start (with a junk byte offered that must not be consumed), then streams
  // the first nbytes of frame_q with random in_valid gaps.
  task automatic send_frame(input int max_gap, input int nbytes, output bit timed_out);
    int tmo;
    timed_out = 1'b0;
    @(negedge clk1);
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    @(negedge clk1);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    chk("ready_after_start", 32'(bus.in_ready), 32'd1);
    chk("err_clear_on_start", 32'(bus.err), 32'd0);
    chk("hold_after_start", 32'(bus.cpu_hold), 32'd1);
    for (int i = 0; i < nbytes; i++) begin
      if (max_gap > 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk1);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = frame_q[i];
      tmo = 0;
      while (!bus.in_ready && tmo < 20) begin
        @(negedge clk1);
        tmo++;
      end
      if (tmo >= 20) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int max_gap, input bit exp_done,
                           input bit exp_err);
    bit to;
    got_data.delete();
    got_addr.delete();
    done_cnt     = 0;
    hold_in_done = 0;
    send_frame(max_gap, frame_q.size(), to);
    chk({tag, "_timeout"}, 32'(to), 32'd0);
    repeat (2) @(negedge clk1);
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'(exp_done));
    chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    chk({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'(!exp_done));
    chk({tag, "_hold_in_done"}, 32'(hold_in_done), 32'd0);
    chk({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_nwrites"}, 32'(got_data.size()), 32'(exp_data.size()));
    for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
      chk($sformatf("%s_addr%0d", tag, k), 32'(got_addr[k]), 32'(exp_addr[k]));
      chk($sformatf("%s_data%0d", tag, k), got_data[k], exp_data[k]);
    end
  endtask

  initial begin
    bit to;
    bit bad;
    int n;
    int addr;

    prog = '{32'h00430800, 32'h00852002, 32'h8C070004, 32'h20E80010, 32'hAC08000C,
             32'h01095022, 32'h10000002, 32'h014B6025, 32'h08000003, 32'hFC000000};
    //          n     addr   corrupt prog gap done err
    vecs[0] = '{10,   0,     1'b0, 1'b1, 3, 1'b1, 1'b0};
    vecs[1] = '{10,   0,     1'b1, 1'b1, 2, 1'b0, 1'b1};
    vecs[2] = '{0,    'h64,  1'b0, 1'b0, 1, 1'b1, 1'b0};
    vecs[3] = '{2,    'h3FF, 1'b0, 1'b0, 1, 1'b1, 1'b0};
    vecs[4] = '{6,    'h1234,1'b0, 1'b0, 0, 1'b1, 1'b0};
    vecs[5] = '{4,    'h100, 1'b1, 1'b0, 0, 1'b0, 1'b1};

    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;

    repeat (2) @(negedge clk1);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk1);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // Reset in the middle of DATA, after one word has been written at address 5.
    build(3, 5, 1'b0, 1'b0);
    got_data.delete();
    got_addr.delete();
    send_frame(0, 10, to);
    chk("mid_timeout", 32'(to), 32'd0);
    chk("mid_one_write", 32'(got_data.size()), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("arst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("arst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("arst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("arst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_err", 32'(bus.err), 32'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    got_data.delete();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    repeat (5) @(negedge clk1);
    bus.in_valid = 1'b0;
    chk("post_rst_no_write", 32'(got_data.size()), 32'd0);
    chk("post_rst_ready", 32'(bus.in_ready), 32'd0);

    foreach (vecs[i]) begin
      build(vecs[i].n, vecs[i].addr, vecs[i].corrupt, vecs[i].use_prog);
      run_frame($sformatf("v%0d", i), vecs[i].max_gap, vecs[i].exp_done, vecs[i].exp_err);
    end

    // Oversize count: ERR right after ADR_L, nothing further accepted.
    frame_q.delete();
    frame_q = '{8'h08, 8'h01, 8'h00, 8'h00};
    got_data.delete();
    got_addr.delete();
    done_cnt = 0;
    send_frame(1, 4, to);
    chk("big_timeout", 32'(to), 32'd0);
    chk("big_err", 32'(bus.err), 32'd1);
    chk("big_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (3) @(negedge clk1);
    bus.in_valid = 1'b0;
    chk("big_ready_held", 32'(bus.in_ready), 32'd0);
    chk("big_hold", 32'(bus.cpu_hold), 32'd1);
    chk("big_no_write", 32'(got_data.size()), 32'd0);
    chk("big_no_done", 32'(done_cnt), 32'd0);

    for (int r = 0; r < 6; r++) begin
      n    = $urandom_range(12, 1);
      addr = $urandom_range(65535, 0);
      bad  = 1'($urandom_range(1, 0));
      build(n, addr, bad, 1'b0);
      run_frame($sformatf("rnd%0d", r), $urandom_range(3, 0), !bad, bad);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
